image_auto_stretch: RTL and testbench

Per-channel automatic contrast stretch for 24-bit RGB888 video, placed directly upstream of the hue-adjust stage in the HDMI processing chain. During each frame it collects per-channel min/max over active pixels. In vertical blanking a serial divider computes per-channel gains. The following frame is linearly remapped so each channel spans 0..255, and the 3-cycle pipelined result goes to the hue stage with matching vs/de delay.

---
 rtl/image_stretch_pkg.sv | 22 ++
 rtl/stretch_serial_div.sv | 57 +++++
 rtl/image_auto_stretch.sv | 251 +++++++++++++++++++++++++
 tb/tb_image_auto_stretch.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/image_stretch_pkg.sv
// Shared types and constants for the per-channel RGB888 auto contrast stretch.
package image_stretch_pkg;

    localparam int DATA_W   = 8;
    localparam int COEF_W   = 16;
    localparam int DIV_ITER = 16;

    localparam logic [COEF_W-1:0] STRETCH_NUM = 16'd65280;
    localparam logic [COEF_W-1:0] UNITY_GAIN  = 16'd256;

    typedef logic [DATA_W-1:0] pix_t;
    typedef logic [COEF_W-1:0] coef_t;

    typedef enum logic [2:0] {
        IDLE,
        DIV_R,
        DIV_G,
        DIV_B,
        COMMIT
    } state_t;

endpackage

// File: rtl/stretch_serial_div.sv
// 16/8 restoring divider, one quotient bit per cycle; o_done pulses the cycle after the last bit.
module stretch_serial_div
    import image_stretch_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  coef_t       i_dividend,
    input  pix_t        i_divisor,
    output coef_t       o_quot,
    output logic        o_done
);

    pix_t       r_rem;
    coef_t      r_q;
    pix_t       r_div;
    logic [4:0] r_cnt;
    logic       r_done;

    logic [DATA_W:0] w_shift;
    logic            w_ge;
    pix_t            w_diff;

    // Partial remainder stays below the divisor, so the 8-bit difference never wraps.
    assign w_shift = {r_rem, r_q[COEF_W-1]};
    assign w_ge    = (w_shift >= {1'b0, r_div});
    assign w_diff  = w_shift[DATA_W-1:0] - r_div;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rem  <= '0;
            r_q    <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem <= '0;
                r_q   <= i_dividend;
                r_div <= i_divisor;
                r_cnt <= 5'(DIV_ITER);
            end else if (r_cnt != 5'd0) begin
                r_rem <= w_ge ? w_diff : w_shift[DATA_W-1:0];
                r_q   <= {r_q[COEF_W-2:0], w_ge};
                r_cnt <= r_cnt - 5'd1;
                if (r_cnt == 5'd1) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_quot = r_q;
    assign o_done = r_done;

endmodule

// File: rtl/image_auto_stretch.sv
// Per-channel min/max contrast stretch: frame statistics, blanking-time gain solve, 3-stage remap.
module image_auto_stretch
    import image_stretch_pkg::*;
#(
    parameter int MIN_RANGE = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic        i_vs,
    input  logic        i_de,
    input  logic [23:0] i_data,
    output logic        o_vs,
    output logic        o_de,
    output logic [23:0] o_data,
    output logic        o_busy
);

    function automatic pix_t f_range(input pix_t mx, input pix_t mn);
        return mx - mn;
    endfunction

    function automatic logic f_valid(input pix_t mx, input pix_t mn);
        return (mx >= mn) && ((mx - mn) >= pix_t'(MIN_RANGE));
    endfunction

    function automatic pix_t f_sub_floor(input pix_t x, input pix_t off);
        logic signed [DATA_W:0] diff;
        diff = $signed({1'b0, x}) - $signed({1'b0, off});
        return (diff < 0) ? '0 : diff[DATA_W-1:0];
    endfunction

    function automatic pix_t f_sat8(input coef_t v);
        return (|v[COEF_W-1:DATA_W]) ? '1 : v[DATA_W-1:0];
    endfunction

    pix_t [2:0]  w_pix;
    logic        r_vs_d;
    logic        w_edge;

    pix_t [2:0]  r_cur_min, r_cur_max;
    pix_t [2:0]  r_snap_min, r_snap_max;
    pix_t [2:0]  r_job_min, r_job_max;

    state_t      r_state, w_state_next;
    logic [4:0]  r_cnt, w_cnt_next;
    logic        w_div_start;
    pix_t        w_divisor;
    coef_t       w_quot;
    logic        w_div_done;

    pix_t        w_res_min, w_res_max;
    logic        w_res_ok;
    coef_t       w_res_gain;
    pix_t        w_res_off;

    coef_t [2:1] r_pend_gain;
    pix_t  [2:1] r_pend_off;
    coef_t [2:0] r_act_gain;
    pix_t  [2:0] r_act_off;

    logic        r_vs_p0, r_vld_p0, r_en_p0;
    pix_t  [2:0] r_x_p0, r_d_p0;
    coef_t [2:0] r_gain_p0;
    logic        r_vs_p1, r_vld_p1, r_en_p1;
    pix_t  [2:0] r_x_p1;
    coef_t [2:0] r_ps_p1;
    logic        r_vs_p2, r_vld_p2;
    logic [23:0] r_data_p2;

    assign w_pix  = i_data;
    assign w_edge = i_vs & ~r_vs_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vs_d     <= 1'b0;
            r_cur_min  <= {3{8'hFF}};
            r_cur_max  <= '0;
            r_snap_min <= {3{8'hFF}};
            r_snap_max <= '0;
        end else begin
            r_vs_d <= i_vs;
            if (w_edge) begin
                r_snap_min <= r_cur_min;
                r_snap_max <= r_cur_max;
                r_cur_min  <= {3{8'hFF}};
                r_cur_max  <= '0;
            end else if (i_de) begin
                for (int c = 0; c < 3; c++) begin
                    if (w_pix[c] < r_cur_min[c]) r_cur_min[c] <= w_pix[c];
                    if (w_pix[c] > r_cur_max[c]) r_cur_max[c] <= w_pix[c];
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Each DIV state: count 0 loads the divider, counts 1..16 are its iterations.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_div_start  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_edge) begin
                    w_state_next = DIV_R;
                    w_cnt_next   = '0;
                end
            end
            DIV_R, DIV_G, DIV_B: begin
                w_div_start = (r_cnt == 5'd0);
                if (r_cnt == 5'(DIV_ITER)) begin
                    w_cnt_next = '0;
                    if (r_state == DIV_R)      w_state_next = DIV_G;
                    else if (r_state == DIV_G) w_state_next = DIV_B;
                    else                       w_state_next = COMMIT;
                end else begin
                    w_cnt_next = r_cnt + 5'd1;
                end
            end
            COMMIT:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Red loads straight from the snapshot, before the job copy exists.
    always_comb begin
        w_divisor = f_range(r_snap_max[2], r_snap_min[2]);
        case (r_state)
            DIV_G:   w_divisor = f_range(r_job_max[1], r_job_min[1]);
            DIV_B:   w_divisor = f_range(r_job_max[0], r_job_min[0]);
            default: ;
        endcase
    end

    stretch_serial_div u_div (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (w_div_start),
        .i_dividend (STRETCH_NUM),
        .i_divisor  (w_divisor),
        .o_quot     (w_quot),
        .o_done     (w_div_done)
    );

    // A quotient lands in the cycle after its DIV state, so the finished channel lags by one.
    always_comb begin
        w_res_max = r_job_max[0];
        w_res_min = r_job_min[0];
        case (r_state)
            DIV_G: begin
                w_res_max = r_job_max[2];
                w_res_min = r_job_min[2];
            end
            DIV_B: begin
                w_res_max = r_job_max[1];
                w_res_min = r_job_min[1];
            end
            default: ;
        endcase
        w_res_ok   = f_valid(w_res_max, w_res_min);
        w_res_gain = w_res_ok ? w_quot : UNITY_GAIN;
        w_res_off  = w_res_ok ? w_res_min : '0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_job_min   <= '0;
            r_job_max   <= '0;
            r_pend_gain <= {2{UNITY_GAIN}};
            r_pend_off  <= '0;
            r_act_gain  <= {3{UNITY_GAIN}};
            r_act_off   <= '0;
        end else begin
            if (r_state == DIV_R && r_cnt == 5'd0) begin
                r_job_min <= r_snap_min;
                r_job_max <= r_snap_max;
            end
            if (w_div_done && r_state == DIV_G) begin
                r_pend_gain[2] <= w_res_gain;
                r_pend_off[2]  <= w_res_off;
            end
            if (w_div_done && r_state == DIV_B) begin
                r_pend_gain[1] <= w_res_gain;
                r_pend_off[1]  <= w_res_off;
            end
            if (r_state == COMMIT) begin
                r_act_gain <= {r_pend_gain[2], r_pend_gain[1], w_res_gain};
                r_act_off  <= {r_pend_off[2], r_pend_off[1], w_res_off};
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vs_p0   <= 1'b0;
            r_vld_p0  <= 1'b0;
            r_en_p0   <= 1'b0;
            r_x_p0    <= '0;
            r_d_p0    <= '0;
            r_gain_p0 <= '0;
            r_vs_p1   <= 1'b0;
            r_vld_p1  <= 1'b0;
            r_en_p1   <= 1'b0;
            r_x_p1    <= '0;
            r_ps_p1   <= '0;
            r_vs_p2   <= 1'b0;
            r_vld_p2  <= 1'b0;
            r_data_p2 <= '0;
        end else begin
            // S1: offset removal; gain travels with the pixel so a COMMIT cannot split a pixel
            r_vs_p0   <= i_vs;
            r_vld_p0  <= i_de;
            r_en_p0   <= i_en;
            r_x_p0    <= w_pix;
            r_gain_p0 <= r_act_gain;
            for (int c = 0; c < 3; c++) begin
                r_d_p0[c] <= f_sub_floor(w_pix[c], r_act_off[c]);
            end
            // S2: gain multiply, keeping only the integer part of the 8.8 product
            r_vs_p1  <= r_vs_p0;
            r_vld_p1 <= r_vld_p0;
            r_en_p1  <= r_en_p0;
            r_x_p1   <= r_x_p0;
            for (int c = 0; c < 3; c++) begin
                r_ps_p1[c] <= coef_t'((24'(r_d_p0[c]) * 24'(r_gain_p0[c])) >> DATA_W);
            end
            // S3: saturate and select stretched or raw pixel
            r_vs_p2  <= r_vs_p1;
            r_vld_p2 <= r_vld_p1;
            r_data_p2 <= (r_en_p1 && r_vld_p1)
                       ? {f_sat8(r_ps_p1[2]), f_sat8(r_ps_p1[1]), f_sat8(r_ps_p1[0])}
                       : r_x_p1;
        end
    end

    assign o_vs   = r_vs_p2;
    assign o_de   = r_vld_p2;
    assign o_data = r_data_p2;
    assign o_busy = (r_state != IDLE);

endmodule

// File: tb/tb_image_auto_stretch.sv
// Scoreboard bench for image_auto_stretch: a frame-level behavioural model predicts every output cycle.
module tb_image_auto_stretch;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        en   = 1'b1;
    logic        vs   = 1'b0;
    logic        de   = 1'b0;
    logic [23:0] data = '0;
    logic        o_vs, o_de, o_busy;
    logic [23:0] o_data;

    int n_cmp = 0;
    int n_bad = 0;

    logic [25:0] sb[$];

    int m_gain[3], m_off[3], m_pgain[3], m_poff[3], m_min[3], m_max[3];
    bit m_prev_vs, m_busy;
    int m_t, m_commit_at;
    int probe[5] = '{50, 200, 125, 30, 250};

    always #5 clk = ~clk;

    image_auto_stretch #(.MIN_RANGE(16)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_en   (en),
        .i_vs   (vs),
        .i_de   (de),
        .i_data (data),
        .o_vs   (o_vs),
        .o_de   (o_de),
        .o_data (o_data),
        .o_busy (o_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s at t=%0d: got %0h, expected %0h", tag, m_t, obs, exp_v);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < 3; c++) begin
            m_gain[c] = 256;
            m_off[c]  = 0;
            m_min[c]  = 255;
            m_max[c]  = 0;
        end
        m_prev_vs = 1'b0;
        m_busy    = 1'b0;
    endfunction

    function automatic logic [7:0] stretch(input logic [7:0] x, input int g, input int o);
        int d, y;
        d = (int'(x) > o) ? int'(x) - o : 0;
        y = (d * g) / 256;
        if (y > 255) y = 255;
        return 8'(y);
    endfunction

    function automatic logic [23:0] pix(input int mode, input int i);
        logic [7:0] r, g, b;
        r = 8'($urandom());
        g = 8'($urandom());
        b = 8'($urandom());
        case (mode)
            1: begin
                if (i == 0)      begin r = 8'd50;  g = 8'd50;  b = 8'd100; end
                else if (i == 1) begin r = 8'd200; g = 8'd200; b = 8'd110; end
                else begin
                    r = 8'($urandom_range(200, 50));
                    g = 8'($urandom_range(200, 50));
                    b = 8'($urandom_range(110, 100));
                end
            end
            2: begin
                if (i < 5) begin
                    r = 8'(probe[i]);
                    g = 8'(probe[4 - i]);
                end
            end
            3: begin
                if (i == 0)      begin r = 8'd100; g = 8'd100; b = 8'd100; end
                else if (i == 1) begin r = 8'd110; g = 8'd110; b = 8'd110; end
                else if (i == 2) begin r = 8'd105; g = 8'd105; b = 8'd105; end
                else begin
                    r = 8'($urandom_range(110, 100));
                    g = 8'($urandom_range(110, 100));
                    b = 8'($urandom_range(110, 100));
                end
            end
            default: ;
        endcase
        return {r, g, b};
    endfunction

    // One pixel clock: check what is on the outputs now, drive a new input, advance the model.
    task automatic step(input bit v, input bit d, input bit e, input logic [23:0] px);
        logic [25:0] want;
        logic [23:0] y;
        int rng;
        if (sb.size() >= 3) begin
            want = sb.pop_front();
            chk("out", {6'd0, o_vs, o_de, o_data}, {6'd0, want});
        end
        chk("busy", {31'd0, o_busy}, {31'd0, m_busy});
        vs   = v;
        de   = d;
        en   = e;
        data = px;
        for (int c = 0; c < 3; c++) begin
            y[c*8 +: 8] = (d && e) ? stretch(px[c*8 +: 8], m_gain[c], m_off[c]) : px[c*8 +: 8];
        end
        sb.push_back({v, d, y});
        if (v && !m_prev_vs) begin
            if (!m_busy) begin
                for (int c = 0; c < 3; c++) begin
                    rng = m_max[c] - m_min[c];
                    if (m_max[c] >= m_min[c] && rng >= 16) begin
                        m_pgain[c] = 65280 / rng;
                        m_poff[c]  = m_min[c];
                    end else begin
                        m_pgain[c] = 256;
                        m_poff[c]  = 0;
                    end
                end
                m_busy      = 1'b1;
                m_commit_at = m_t + 52;
            end
            for (int c = 0; c < 3; c++) begin
                m_min[c] = 255;
                m_max[c] = 0;
            end
        end else if (d) begin
            for (int c = 0; c < 3; c++) begin
                if (int'(px[c*8 +: 8]) < m_min[c]) m_min[c] = int'(px[c*8 +: 8]);
                if (int'(px[c*8 +: 8]) > m_max[c]) m_max[c] = int'(px[c*8 +: 8]);
            end
        end
        m_prev_vs = v;
        if (m_busy && m_t == m_commit_at) begin
            for (int c = 0; c < 3; c++) begin
                m_gain[c] = m_pgain[c];
                m_off[c]  = m_poff[c];
            end
            m_busy = 1'b0;
        end
        m_t++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        vs   = 1'b0;
        de   = 1'b0;
        data = '0;
        #1;
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_out", {6'd0, o_vs, o_de, o_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        repeat (3) sb.push_back('0);
        model_reset();
    endtask

    task automatic frame(input int mode, input bit e, input int npix);
        repeat (4)  step(1'b1, 1'b0, e, 24'($urandom()));
        repeat (60) step(1'b0, 1'b0, e, 24'($urandom()));
        for (int i = 0; i < npix; i++) step(1'b0, 1'b1, e, pix(mode, i));
        repeat (4)  step(1'b0, 1'b0, e, 24'($urandom()));
    endtask

    // Second vs edge 20 cycles after the first, with extreme pixels between them.
    task automatic double_edge_frame(input int npix);
        repeat (4)  step(1'b1, 1'b0, 1'b1, 24'($urandom()));
        repeat (12) step(1'b0, 1'b0, 1'b1, 24'($urandom()));
        step(1'b0, 1'b1, 1'b1, 24'h000000);
        step(1'b0, 1'b1, 1'b1, 24'hFFFFFF);
        step(1'b0, 1'b1, 1'b1, 24'h00FF00);
        step(1'b0, 1'b1, 1'b1, 24'hFF00FF);
        repeat (4)  step(1'b1, 1'b0, 1'b1, 24'($urandom()));
        repeat (60) step(1'b0, 1'b0, 1'b1, 24'($urandom()));
        for (int i = 0; i < npix; i++) step(1'b0, 1'b1, 1'b1, pix(2, i));
        repeat (4)  step(1'b0, 1'b0, 1'b1, 24'($urandom()));
    endtask

    initial begin
        m_t = 0;
        m_commit_at = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        frame(0, 1'b1, 48);
        frame(1, 1'b1, 48);
        frame(2, 1'b1, 48);
        frame(3, 1'b1, 48);
        frame(3, 1'b1, 48);
        frame(1, 1'b1, 48);
        double_edge_frame(48);
        frame(1, 1'b1, 48);

        repeat (4)  step(1'b1, 1'b0, 1'b1, 24'($urandom()));
        repeat (21) step(1'b0, 1'b0, 1'b1, 24'($urandom()));
        do_reset();

        frame(2, 1'b1, 48);
        frame(1, 1'b1, 48);
        frame(2, 1'b0, 48);
        frame(2, 1'b1, 48);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
